// File: rtl/maj7_pkg.sv
// Shared definitions for the 7-input truth-table sweeper: sweep FSM states,
// input/minterm counts and the truth-table / minterm-index types.
package maj7_pkg;

    localparam int unsigned NUM_IN       = 7;
    localparam int unsigned NUM_MINTERMS = 128;

    typedef logic [NUM_MINTERMS-1:0] tt_t;
    typedef logic [NUM_IN-1:0]       idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/maj7_tt_sweeper_if.sv
// Bundle between the sweeper, the test harness and the network under test.
//   master : harness side (drives start/expect_tt, supplies the network output y)
//   slave  : sweeper side (drives minterm x, status and captured table)
interface maj7_tt_sweeper_if;
    import maj7_pkg::*;

    logic       start;
    tt_t        expect_tt;
    idx_t       x;
    logic       y;
    logic       busy;
    logic       done;
    tt_t        tt;
    logic       match;
    idx_t       first_mm;
    logic [7:0] mm_cnt;

    modport master (
        output start, expect_tt, y,
        input  x, busy, done, tt, match, first_mm, mm_cnt
    );

    modport slave (
        input  start, expect_tt, y,
        output x, busy, done, tt, match, first_mm, mm_cnt
    );

endinterface

// File: rtl/maj7_capture_pipe.sv
// (valid, index) delay line that tracks the latency of the attached network.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_idx    : minterm issued this cycle
//   out_valid, out_idx  : minterm whose network output is on y this cycle
//   empty               : no entry will remain in the line after this edge
// With LAT = 0 the line is a wire: the issue stage is the capture stage.
module maj7_capture_pipe
    import maj7_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  idx_t in_idx,
    output logic out_valid,
    output idx_t out_idx,
    output logic empty
);

    if (LAT == 0) begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_valid      = in_valid;
        assign out_idx        = in_idx;
        assign empty          = 1'b1;
    end else begin : g_reg
        logic [LAT-1:0] vld_q;
        idx_t           idx_q [LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < int'(LAT); i++) idx_q[i] <= '0;
            end else begin
                vld_q[0] <= in_valid;
                idx_q[0] <= in_idx;
                for (int i = 1; i < int'(LAT); i++) begin
                    vld_q[i] <= vld_q[i-1];
                    idx_q[i] <= idx_q[i-1];
                end
            end
        end

        // The last stage is consumed on this edge, so only earlier stages
        // (and the issue input, idle while draining) keep the line occupied.
        always_comb begin
            empty = 1'b1;
            for (int i = 0; i < int'(LAT) - 1; i++) begin
                if (vld_q[i]) empty = 1'b0;
            end
        end

        assign out_valid = vld_q[LAT-1];
        assign out_idx   = idx_q[LAT-1];
    end

endmodule

// File: rtl/maj7_tt_sweeper.sv
// Sequential truth-table extractor for a 7-input network. On an accepted start
// it issues minterms 0..127 on x, one per cycle, captures y LAT cycles later
// into tt, and reports whether tt equals the expected table latched at start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : maj7_tt_sweeper_if.slave (start, expect_tt, y in;
//                x, busy, done, tt, match, first_mm, mm_cnt out)
//   LAT        : register stages inside the attached network, 0..7
// Build option: MAJ7_MISMATCH_LOG_EN adds the per-capture comparator that
// records the lowest mismatching minterm (first_mm) and the mismatch count
// (mm_cnt); without it both read 0 and match is a full-table compare in DONE.
module maj7_tt_sweeper
    import maj7_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    maj7_tt_sweeper_if.slave  bus
);

    localparam logic [7:0] LastIdx = 8'(NUM_MINTERMS - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q;
    tt_t        exp_q;
    tt_t        tt_q;
    logic       match_q;
    logic       match_now;
    logic       accept;
    logic       issue;
    logic       busy;
    logic       done;
    logic       cap_valid;
    idx_t       cap_idx;
    logic       pipe_empty;

    assign accept = (state_q == StIdle) && bus.start;

    maj7_capture_pipe #(
        .LAT (LAT)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_idx    (cnt_q[NUM_IN-1:0]),
        .out_valid (cap_valid),
        .out_idx   (cap_idx),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StSweep;
            StSweep: if (cnt_q == LastIdx) state_d = (LAT == 0) ? StDone : StDrain;
            StDrain: if (pipe_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            StSweep: begin
                issue = 1'b1;
                busy  = 1'b1;
            end
            StDrain: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            match_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            exp_q   <= bus.expect_tt;
            tt_q    <= '0;
            match_q <= 1'b0;
        end else begin
            // Counter parks on the last minterm so x holds 127 while draining.
            if (state_q == StSweep && cnt_q != LastIdx) cnt_q <= cnt_q + 8'd1;
            if (cap_valid) tt_q[cap_idx] <= bus.y;
            if (state_q == StDone) match_q <= match_now;
        end
    end

`ifdef MAJ7_MISMATCH_LOG_EN
    idx_t       first_q;
    logic [7:0] mm_cnt_q;

    // Captures arrive in ascending index order, so the first logged mismatch
    // is the lowest one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= '0;
            mm_cnt_q <= '0;
        end else if (accept) begin
            first_q  <= '0;
            mm_cnt_q <= '0;
        end else if (cap_valid && (bus.y != exp_q[cap_idx])) begin
            if (mm_cnt_q == 8'd0) first_q <= cap_idx;
            mm_cnt_q <= mm_cnt_q + 8'd1;
        end
    end

    assign match_now    = (mm_cnt_q == 8'd0);
    assign bus.first_mm = first_q;
    assign bus.mm_cnt   = mm_cnt_q;
`else
    assign match_now    = (tt_q == exp_q);
    assign bus.first_mm = '0;
    assign bus.mm_cnt   = '0;
`endif

    // During DONE the final result is shown directly; it is then held.
    assign bus.match = (state_q == StDone) ? match_now : match_q;
    assign bus.x     = cnt_q[NUM_IN-1:0];
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.tt    = tt_q;

endmodule
